branch_redirect_unit: RTL and testbench

Fetch-side consumer of the ID-stage branch decision. Takes the registered-free `brCond` verdict, branch target and link request produced by the ID-stage condition check. Owns the program counter, redirects fetch, flushes IF/ID on taken branches, and issues the `$ra` link write for JAL. Sits between the hazard unit, the ID-stage branch logic and the IF stage / register file write port.

---
 rtl/branch_redirect_unit.sv | 103 ++++++++++
 tb/tb_branch_redirect_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: owns the fetch PC, applies ID-stage branch redirects,
// flushes IF/ID on a taken redirect and issues the one-cycle JAL link write.
module branch_redirect_unit #(
    parameter int unsigned            WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0]    RESET_PC = '0,
    parameter int unsigned            CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 brCond,
    input  logic                 isLink,
    input  logic [WORD_LEN-1:0]  brTarget,
    input  logic [WORD_LEN-1:0]  idPC,
    output logic [WORD_LEN-1:0]  pcOut,
    output logic                 flushIFID,
    output logic                 linkWrEn,
    output logic [4:0]           linkDest,
    output logic [WORD_LEN-1:0]  linkData,
    output logic                 alignErr,
    output logic [CNT_W-1:0]     takenCount
);

    localparam logic [4:0] LINK_REG = 5'd31;

    // SHADOW marks the cycle in which ID holds the bubble left by a redirect.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_LEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  link_we_q, link_we_d;
    logic [WORD_LEN-1:0]   link_data_q, link_data_d;
    logic                  align_q, align_d;
    logic                  taken_c;

    // A redirect is accepted only from RUN and only when not stalled.
    assign taken_c   = (state_q == ST_RUN) && !freeze && brCond;
    assign flushIFID = taken_c && !rst;

    // Next-state, next-PC, counter and one-shot pulse computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        link_we_d   = taken_c && isLink;
        link_data_d = (taken_c && isLink) ? idPC : '0;
        align_d     = taken_c && (brTarget[1:0] != 2'b00);

        if (!freeze) begin
            case (state_q)
                ST_RUN: begin
                    if (brCond) begin
                        pc_d    = {brTarget[WORD_LEN-1:2], 2'b00};
                        state_d = ST_SHADOW;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_d = pc_q + WORD_LEN'(4);
                    end
                end
                ST_SHADOW: begin
                    pc_d    = pc_q + WORD_LEN'(4);
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            cnt_q       <= '0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            align_q     <= align_d;
        end
    end

    assign pcOut      = pc_q;
    assign takenCount = cnt_q;
    assign linkWrEn   = link_we_q;
    assign linkDest   = link_we_q ? LINK_REG : 5'd0;
    assign linkData   = link_data_q;
    assign alignErr   = align_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed test-plan sequences
// followed by random stimulus, all compared against a cycle-level model.
module tb_branch_redirect_unit;

    localparam int unsigned     WL  = 32;
    localparam int unsigned     CW  = 3;
    localparam logic [WL-1:0]   RPC = 32'h0;
    localparam int              CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst, freeze, brCond, isLink;
    logic [WL-1:0]  brTarget, idPC;
    logic [WL-1:0]  pcOut, linkData;
    logic           flushIFID, linkWrEn, alignErr;
    logic [4:0]     linkDest;
    logic [CW-1:0]  takenCount;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: fetch PC, "ID holds a bubble" flag, taken count,
    // and the pulses scheduled for the next cycle.
    logic [WL-1:0]  m_pc, m_ld;
    bit             m_bubble, m_lk, m_al;
    int             m_cnt;

    always #5 clk = ~clk;

    branch_redirect_unit #(.WORD_LEN(WL), .RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .brCond(brCond), .isLink(isLink),
        .brTarget(brTarget), .idPC(idPC), .pcOut(pcOut), .flushIFID(flushIFID),
        .linkWrEn(linkWrEn), .linkDest(linkDest), .linkData(linkData),
        .alignErr(alignErr), .takenCount(takenCount)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_ld = '0; m_bubble = 0; m_lk = 0; m_al = 0; m_cnt = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic r, input logic f, input logic b, input logic l,
                        input logic [WL-1:0] t, input logic [WL-1:0] p);
        bit taken;
        @(negedge clk);
        rst = r; freeze = f; brCond = b; isLink = l; brTarget = t; idPC = p;
        #1;
        taken = !r && !f && !m_bubble && b;
        check("pcOut", pcOut, m_pc);
        check("flushIFID", flushIFID, taken);
        check("linkWrEn", linkWrEn, m_lk);
        check("linkDest", linkDest, m_lk ? 5'd31 : 5'd0);
        if (m_lk) check("linkData", linkData, m_ld);
        check("alignErr", alignErr, m_al);
        check("takenCount", takenCount, m_cnt);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_lk = taken && l;
            m_ld = (taken && l) ? p : '0;
            m_al = taken && (t % 4 != 0);
            if (!f) begin
                if (taken) begin
                    m_pc = t - (t % 4);
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_bubble = 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_bubble = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; brCond = 1'b0; isLink = 1'b0;
        brTarget = '0; idPC = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Free-running fetch, then a taken branch at 0x10.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("pc_after_4", pcOut, 32'h10);
        step(0, 0, 1, 0, 32'h100, 32'h14);
        #1 check("pc_redirect", pcOut, 32'h100);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("pc_after_shadow", pcOut, 32'h104);

        // JAL with link write.
        step(0, 0, 1, 1, 32'h400, 32'h20);
        #1 check("jal_link_data", linkData, 32'h20);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Stall with a pending branch, then release.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h500, 32'h0);
        step(0, 0, 1, 0, 32'h500, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Branch held two cycles with a misaligned target.
        step(0, 0, 1, 0, 32'h203, 32'h0);
        step(0, 0, 1, 0, 32'h203, 32'h0);
        #1 check("pc_after_drop", pcOut, 32'h204);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Counter saturation.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 32'h1000 + 32'(i * 64), 32'h0);
            step(0, 0, 0, 0, 32'h0, 32'h0);
        end
        #1 check("cnt_saturated", takenCount, 3'd7);

        // PC wrap through the top of the address space.
        step(0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("pc_wrap", pcOut, 32'h0);

        // Reset while in SHADOW with a link pulse pending.
        step(0, 0, 1, 1, 32'h702, 32'h44);
        step(1, 0, 1, 1, 32'h900, 32'h88);
        #1 check("rst_mid_shadow_link", linkWrEn, 1'b0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [WL-1:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), t, 32'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
